// File: rtl/seq_rec_pkg.sv
// Shared types and constants for the parameterised serial sequence recognizer.
package seq_rec_pkg;

   typedef enum logic {
      UNLOADED = 1'b0,
      RUN      = 1'b1
   } seq_state_t;

   localparam int LEN_MIN = 2;
   localparam int LEN_MAX = 16;

   // Width of a counter that must reach len-1; never narrower than one bit.
   function automatic int fill_width(input int len);
      int w;
      w = $clog2(len);
      if (w < 1) begin
         w = 1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear; holds at all-ones.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   localparam logic [W-1:0] Q_MAX = {W{1'b1}};

   // Count register: reset and clear dominate, increment stops at Q_MAX.
   always_ff @(posedge clock) begin
      if (reset) begin
         q <= {W{1'b0}};
      end else if (clr) begin
         q <= {W{1'b0}};
      end else if (inc && (q != Q_MAX)) begin
         q <= q + W'(1);
      end else begin
         q <= q;
      end
   end

endmodule

// File: rtl/param_sequence_recognizer.sv
// Serial pattern recognizer with a loadable LEN-bit target, overlapping or
// non-overlapping detection, a Mealy match flag and a saturating match count.
module param_sequence_recognizer
   import seq_rec_pkg::*;
#(
   parameter int LEN   = 4,
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             x,
   input  logic             x_valid,
   input  logic             load,
   input  logic [LEN-1:0]   pattern,
   input  logic             overlap,
   output logic             z,
   output logic [CNT_W-1:0] match_count,
   output logic             armed
);

   localparam int                FILL_W    = fill_width(LEN);
   localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(LEN - 1);

   seq_state_t        state_r, state_nxt_s;
   logic [LEN-1:0]    pattern_r, pattern_nxt_s;
   logic [LEN-2:0]    history_r, history_nxt_s;
   logic [FILL_W-1:0] fill_r, fill_nxt_s;
   logic [LEN-1:0]    window_s;
   logic              accept_s;
   logic              full_s;

   // Match decode: the candidate window is the stored history plus the live bit.
   always_comb begin
      window_s = {history_r, x};
      accept_s = (state_r == RUN) && x_valid && !load;
      full_s   = (fill_r == FILL_FULL);
      if (accept_s && full_s && (window_s == pattern_r)) begin
         z = 1'b1;
      end else begin
         z = 1'b0;
      end
      armed = (state_r == RUN);
   end

   // Next-state: any load (re)arms; RUN is only left through reset.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         UNLOADED: begin
            if (load) begin
               state_nxt_s = RUN;
            end else begin
               state_nxt_s = UNLOADED;
            end
         end
         RUN: begin
            state_nxt_s = RUN;
         end
         default: begin
            state_nxt_s = UNLOADED;
         end
      endcase
   end

   // Datapath next values: load restarts, accepted bits shift history and fill.
   always_comb begin
      pattern_nxt_s = pattern_r;
      history_nxt_s = history_r;
      fill_nxt_s    = fill_r;
      if (load) begin
         pattern_nxt_s = pattern;
         history_nxt_s = {(LEN-1){1'b0}};
         fill_nxt_s    = {FILL_W{1'b0}};
      end else if (accept_s) begin
         history_nxt_s = window_s[LEN-2:0];
         // A non-overlapping hit forces LEN fresh bits before the next one.
         if (z && !overlap) begin
            fill_nxt_s = {FILL_W{1'b0}};
         end else if (!full_s) begin
            fill_nxt_s = fill_r + FILL_W'(1);
         end else begin
            fill_nxt_s = fill_r;
         end
      end else begin
         history_nxt_s = history_r;
         fill_nxt_s    = fill_r;
      end
   end

   // State and datapath registers with synchronous reset priority.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r   <= UNLOADED;
         pattern_r <= {LEN{1'b0}};
         history_r <= {(LEN-1){1'b0}};
         fill_r    <= {FILL_W{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         pattern_r <= pattern_nxt_s;
         history_r <= history_nxt_s;
         fill_r    <= fill_nxt_s;
      end
   end

   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clock (clock),
      .reset (reset),
      .clr   (load),
      .inc   (z),
      .q     (match_count)
   );

endmodule

// File: tb/tb_param_sequence_recognizer.sv
// Self-checking bench: directed scenarios plus random traffic against a
// queue-based reference model, on a LEN=4/CNT_W=8 and a LEN=2/CNT_W=2 instance.
module tb_param_sequence_recognizer;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic       rst_a, x_a, xv_a, ld_a, ov_a, z_a, armed_a;
   logic [3:0] pat_a;
   logic [7:0] mc_a;
   logic       rst_b, x_b, xv_b, ld_b, ov_b, z_b, armed_b;
   logic [1:0] pat_b;
   logic [1:0] mc_b;

   int checks   = 0;
   int failures = 0;

   bit m_armed[2];
   int m_pat[2];
   int m_cnt[2];
   int qa[$];
   int qb[$];
   bit last_z;

   param_sequence_recognizer #(.LEN(4), .CNT_W(8)) dut_a (
      .clock(clock), .reset(rst_a), .x(x_a), .x_valid(xv_a), .load(ld_a),
      .pattern(pat_a), .overlap(ov_a), .z(z_a), .match_count(mc_a), .armed(armed_a)
   );

   param_sequence_recognizer #(.LEN(2), .CNT_W(2)) dut_b (
      .clock(clock), .reset(rst_b), .x(x_b), .x_valid(xv_b), .load(ld_b),
      .pattern(pat_b), .overlap(ov_b), .z(z_b), .match_count(mc_b), .armed(armed_b)
   );

   task automatic check_value(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // A match needs len-1 bits since the window start, then the last len bits equal the pattern.
   function automatic bit model_z(input int q[$], input int len, input bit arm,
                                  input bit ld, input bit xv, input bit x, input int pat);
      int v;
      if (!arm || ld || !xv) return 1'b0;
      if (q.size() < len - 1) return 1'b0;
      v = 0;
      for (int i = q.size() - (len - 1); i < q.size(); i++) v = (v << 1) | q[i];
      v = (v << 1) | int'(x);
      return (v == pat);
   endfunction

   task automatic step(input int d, input bit rst, input bit ld, input bit xv,
                       input bit x, input bit ov, input int pat, input string tag);
      int q[$];
      int len, mx, mask;
      bit ez;
      logic [31:0] gz, gc, ga;
      @(negedge clock);
      rst_a = 1'b0; ld_a = 1'b0; xv_a = 1'b0; x_a = 1'b0; ov_a = 1'b0;
      rst_b = 1'b0; ld_b = 1'b0; xv_b = 1'b0; x_b = 1'b0; ov_b = 1'b0;
      if (d == 0) begin
         rst_a = rst; ld_a = ld; xv_a = xv; x_a = x; ov_a = ov; pat_a = pat[3:0];
         q = qa; len = 4; mx = 255; mask = 15;
      end else begin
         rst_b = rst; ld_b = ld; xv_b = xv; x_b = x; ov_b = ov; pat_b = pat[1:0];
         q = qb; len = 2; mx = 3; mask = 3;
      end
      #1;
      ez = model_z(q, len, m_armed[d], ld, xv, x, m_pat[d]);
      gz = (d == 0) ? 32'(z_a) : 32'(z_b);
      last_z = gz[0];
      check_value({tag, "_z"}, gz, int'(ez));
      @(posedge clock);
      if (rst) begin
         m_armed[d] = 1'b0; m_pat[d] = 0; m_cnt[d] = 0; q.delete();
      end else if (ld) begin
         m_armed[d] = 1'b1; m_pat[d] = pat & mask; m_cnt[d] = 0; q.delete();
      end else if (m_armed[d] && xv) begin
         if (ez && m_cnt[d] < mx) m_cnt[d] = m_cnt[d] + 1;
         if (ez && !ov) q.delete();
         else q.push_back(int'(x));
         if (q.size() > len) void'(q.pop_front());
      end
      if (d == 0) qa = q; else qb = q;
      #1;
      gc = (d == 0) ? 32'(mc_a) : 32'(mc_b);
      ga = (d == 0) ? 32'(armed_a) : 32'(armed_b);
      check_value({tag, "_cnt"}, gc, m_cnt[d]);
      check_value({tag, "_armed"}, ga, int'(m_armed[d]));
   endtask

   task automatic bits_a(input int v, input int n, input bit ov, input string tag);
      for (int i = n - 1; i >= 0; i--) step(0, 1'b0, 1'b0, 1'b1, v[i], ov, 0, tag);
   endtask

   initial begin
      int pulses;
      rst_a = 1'b1; ld_a = 1'b0; xv_a = 1'b0; x_a = 1'b0; ov_a = 1'b0; pat_a = 4'd0;
      rst_b = 1'b1; ld_b = 1'b0; xv_b = 1'b0; x_b = 1'b0; ov_b = 1'b0; pat_b = 2'd0;
      repeat (2) @(posedge clock);

      // Reset state, with reset winning over a simultaneous load and valid bit.
      step(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10, "rst");
      check_value("rst_cnt", mc_a, 0);
      check_value("rst_armed", armed_a, 0);
      step(1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "rstb");

      // Overlapping 1010 over 101010.
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, "ov_ld");
      bits_a(6'b101010, 6, 1'b1, "ov");
      check_value("ov_total", mc_a, 2);

      // Non-overlapping, then two more bits complete a fresh match.
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10, "no_ld");
      bits_a(6'b101010, 6, 1'b0, "no");
      check_value("no_total6", mc_a, 1);
      bits_a(2'b10, 2, 1'b0, "no2");
      check_value("no_total8", mc_a, 2);

      // Gap with x_valid low and junk on x.
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, "gap_ld");
      bits_a(2'b10, 2, 1'b1, "gap");
      for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 0, "gap_idle");
      bits_a(2'b10, 2, 1'b1, "gap2");
      check_value("gap_total", mc_a, 1);

      // Reset mid-stream discards the partial match.
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, "mid_ld");
      bits_a(3'b101, 3, 1'b1, "mid");
      step(0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, "mid_rst");
      check_value("mid_rst_cnt", mc_a, 0);
      check_value("mid_rst_armed", armed_a, 0);
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, "mid_ld2");
      bits_a(1'b0, 1, 1'b1, "mid_bit");
      check_value("mid_total", mc_a, 0);

      // Load with a valid bit ignores that bit; reload mid-match restarts.
      step(0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 10, "ldx");
      bits_a(3'b010, 3, 1'b1, "ldx_bits");
      check_value("ldx_total", mc_a, 0);
      bits_a(3'b101, 3, 1'b1, "rl_pre");
      step(0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 10, "rl_ld");
      bits_a(1'b0, 1, 1'b1, "rl_bit");
      check_value("rl_nomatch", mc_a, 0);
      bits_a(4'b1010, 4, 1'b1, "rl_full");
      check_value("rl_total", mc_a, 1);

      // CNT_W=2, pattern 11, eight ones: seven pulses, count saturates at 3.
      step(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3, "sat_ld");
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 0, "sat");
         if (last_z) pulses++;
      end
      check_value("sat_pulses", pulses, 7);
      check_value("sat_total", mc_b, 3);

      // Random traffic on both instances.
      for (int i = 0; i < 600; i++) begin
         int r, d;
         d = i % 2;
         r = $urandom_range(0, 99);
         step(d, (r < 2), (r >= 2 && r < 8), ($urandom_range(0, 3) != 0),
              1'($urandom), ($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
